// File: rtl/instr_fetch1_queued.sv
// Fetch stage 1: PC queue feeding ITLB/ITag lookups, registered Fetch2 entry with slot mask and flush epoch.
// Latency: push at edge n, issue in cycle n+1, Fetch2 entry at edge n+2; a full queue refuses pushes; i_stall holds the output.
module instr_fetch1_queued #(
    parameter int PC_WIDTH     = 32,
    parameter int FETCH_WIDTH  = 4,
    parameter int INSTR_BYTES  = 4,
    parameter int QUEUE_DEPTH  = 4,
    parameter int EPOCH_WIDTH  = 2,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_stall,
    input  logic                   i_flush,
    input  logic                   i_pc_valid,
    input  logic [PC_WIDTH-1:0]    i_pc,
    output logic                   o_pc_ready,
    input  logic                   i_itlb_avail,
    input  logic                   i_icache_tag_avail,
    output logic                   o_itlb_read,
    output logic                   o_icache_tag_read,
    output logic [PC_WIDTH-1:0]    o_lookup_pc,
    output logic                   o_valid,
    output logic [PC_WIDTH-1:0]    o_pc,
    output logic [FETCH_WIDTH-1:0] o_mask,
    output logic [EPOCH_WIDTH-1:0] o_epoch,
    output logic                   o_starved
);
    localparam int PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W   = $clog2(QUEUE_DEPTH + 1);
    localparam int SCNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int OFF_LSB = $clog2(INSTR_BYTES);

    logic [PC_WIDTH-1:0]    mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [EPOCH_WIDTH-1:0] epoch;
    logic [SCNT_W-1:0]      starve_cnt, starve_nxt;
    logic [FETCH_WIDTH-1:0] head_mask;
    logic                   empty, full, push, issue, blocked, both_avail;

    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(QUEUE_DEPTH));
    assign both_avail = i_itlb_avail & i_icache_tag_avail;
    assign o_pc_ready = ~full & ~i_flush & ~i_rst;
    assign push       = i_pc_valid & o_pc_ready;
    assign issue      = ~empty & both_avail & ~i_stall & ~i_flush;
    assign blocked    = ~empty & ~i_stall & ~i_flush & ~both_avail;

    assign o_itlb_read       = issue;
    assign o_icache_tag_read = issue;
    assign o_lookup_pc       = mem[rd_ptr];

    // Slot i is valid when it lies at or after the PC's position within the block.
    generate
        if (FETCH_WIDTH == 1) begin : g_mask_one
            assign head_mask = '1;
        end else begin : g_mask_off
            localparam int OFF_W = $clog2(FETCH_WIDTH);
            logic [OFF_W-1:0] off;
            assign off       = o_lookup_pc[OFF_LSB +: OFF_W];
            assign head_mask = ~((FETCH_WIDTH'(1) << off) - FETCH_WIDTH'(1));
        end
    endgenerate

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_pc;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)  wr_ptr <= ptr_inc(wr_ptr);
            if (issue) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !issue)      count <= count + CNT_W'(1);
            else if (!push && issue) count <= count - CNT_W'(1);
        end
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (i_flush || empty)
            starve_nxt = '0;
        else if (i_stall)
            starve_nxt = starve_cnt;
        else if (issue)
            starve_nxt = '0;
        else if (blocked && starve_cnt != SCNT_W'(STARVE_LIMIT))
            starve_nxt = starve_cnt + SCNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_cnt <= '0;
            o_starved  <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            o_starved  <= (starve_nxt == SCNT_W'(STARVE_LIMIT));
        end
    end

    // The flush bumps the epoch and exposes it on o_epoch immediately so Fetch2 sees the new epoch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_pc    <= '0;
            o_mask  <= '0;
            o_epoch <= '0;
            epoch   <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
            epoch   <= epoch + EPOCH_WIDTH'(1);
            o_epoch <= epoch + EPOCH_WIDTH'(1);
        end else if (!i_stall) begin
            o_valid <= issue;
            if (issue) begin
                o_pc    <= o_lookup_pc;
                o_mask  <= head_mask;
                o_epoch <= epoch;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch1_queued.sv
// Directed plus random bench for instr_fetch1_queued against a queue-based reference model.
module tb_instr_fetch1_queued;
    localparam int DEPTH = 4;
    localparam int LIMIT = 16;

    logic        i_clk = 1'b0;
    logic        i_rst, i_stall, i_flush, i_pc_valid, i_itlb_avail, i_icache_tag_avail;
    logic [31:0] i_pc;
    logic        o_pc_ready, o_itlb_read, o_icache_tag_read, o_valid, o_starved;
    logic [31:0] o_lookup_pc, o_pc;
    logic [3:0]  o_mask;
    logic [1:0]  o_epoch;

    instr_fetch1_queued dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
        .i_pc_valid(i_pc_valid), .i_pc(i_pc), .o_pc_ready(o_pc_ready),
        .i_itlb_avail(i_itlb_avail), .i_icache_tag_avail(i_icache_tag_avail),
        .o_itlb_read(o_itlb_read), .o_icache_tag_read(o_icache_tag_read),
        .o_lookup_pc(o_lookup_pc), .o_valid(o_valid), .o_pc(o_pc), .o_mask(o_mask),
        .o_epoch(o_epoch), .o_starved(o_starved)
    );

    always #5 i_clk = ~i_clk;

    int          total  = 0;
    int          passes = 0;
    logic [31:0] mq[$];
    logic        m_valid, m_known;
    logic [31:0] m_pc;
    logic [3:0]  m_mask;
    int          m_oep, m_ep, m_starve;

    function automatic logic [3:0] slot_mask(input logic [31:0] pc);
        int off;
        logic [3:0] m;
        off = (pc / 4) % 4;
        m = '0;
        for (int i = 0; i < 4; i++) if (i >= off) m[i] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic stall, input logic flush, input logic pv,
                        input logic [31:0] pc, input logic tlb, input logic tag);
        logic e_ready, e_issue, e_push, e_block;
        i_rst = rst; i_stall = stall; i_flush = flush; i_pc_valid = pv; i_pc = pc;
        i_itlb_avail = tlb; i_icache_tag_avail = tag;
        e_ready = !rst && !flush && (mq.size() < DEPTH);
        e_issue = (mq.size() > 0) && tlb && tag && !stall && !flush;
        e_push  = pv && e_ready;
        e_block = (mq.size() > 0) && !stall && !flush && !(tlb && tag);
        @(negedge i_clk);
        chk("pc_ready", o_pc_ready, e_ready);
        if (m_known) begin
            chk("itlb_read", o_itlb_read, e_issue);
            chk("tag_read", o_icache_tag_read, e_issue);
            if (mq.size() > 0) chk("lookup_pc", o_lookup_pc, mq[0]);
            chk("o_valid", o_valid, m_valid);
            chk("o_pc", o_pc, m_pc);
            chk("o_mask", o_mask, m_mask);
            chk("o_epoch", o_epoch, m_oep);
            chk("o_starved", o_starved, m_starve == LIMIT);
        end
        @(posedge i_clk);
        if (rst) begin
            mq.delete(); m_valid = 0; m_pc = 0; m_mask = 0; m_oep = 0; m_ep = 0; m_starve = 0;
            m_known = 1;
        end else if (flush) begin
            mq.delete(); m_valid = 0; m_ep = (m_ep + 1) % 4; m_oep = m_ep; m_starve = 0;
        end else begin
            if (mq.size() == 0)  m_starve = 0;
            else if (stall)      m_starve = m_starve;
            else if (e_issue)    m_starve = 0;
            else if (e_block && m_starve < LIMIT) m_starve++;
            if (!stall) begin
                m_valid = e_issue;
                if (e_issue) begin m_pc = mq[0]; m_mask = slot_mask(mq[0]); m_oep = m_ep; end
            end
            if (e_issue) void'(mq.pop_front());
            if (e_push) mq.push_back(pc);
        end
        #1;
    endtask

    task automatic idle(input int n, input logic stall, input logic tlb);
        for (int k = 0; k < n; k++) step(0, stall, 0, 0, 32'h0, tlb, 1);
    endtask

    initial begin
        m_known = 0;
        step(1, 0, 0, 1, 32'h55, 1, 1);
        step(1, 0, 0, 0, 32'h0, 1, 1);
        // Single push: lookup next cycle, Fetch2 entry the cycle after
        step(0, 0, 0, 1, 32'h1008, 1, 1);
        idle(2, 0, 1);
        chk("first_mask", o_mask, 4'b1100);
        // Starvation with a full queue and one refused push
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 32'h2000 + 32'(i * 4), 0, 1);
        idle(14, 0, 0);
        chk("starved_set", o_starved, 1'b1);
        idle(6, 0, 1);
        chk("starved_clr", o_starved, 1'b0);
        // Stall holds outputs and the starve counter
        step(0, 0, 0, 1, 32'h3004, 0, 1);
        step(0, 0, 0, 1, 32'h300c, 0, 1);
        step(0, 0, 0, 0, 32'h0, 1, 1);
        idle(3, 1, 0);
        idle(3, 0, 1);
        // Flush under stall with queued PCs, then epoch wrap
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'h4000 + 32'(i * 4), 0, 1);
        step(0, 0, 0, 0, 32'h0, 1, 1);
        step(0, 1, 1, 1, 32'h4444, 1, 1);
        chk("flush_epoch", o_epoch, 2'd1);
        step(0, 0, 0, 1, 32'h5008, 1, 1);
        idle(2, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 32'h0, 1, 1);
        chk("epoch_wrap", o_epoch, 2'd0);
        // Steady state at count 2 with simultaneous push/issue, wrapping pointers
        step(0, 0, 0, 1, 32'h6000, 0, 1);
        step(0, 0, 0, 1, 32'h6004, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 32'h6100 + 32'(i * 4), 1, 1);
        idle(3, 0, 1);
        // Reset mid-stream with a full queue and a valid Fetch2 entry
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'h7000 + 32'(i * 4), 0, 1);
        step(0, 0, 0, 0, 32'h0, 1, 1);
        step(0, 1, 0, 1, 32'h7100, 0, 1);
        step(1, 0, 0, 1, 32'h7200, 1, 1);
        step(0, 0, 0, 0, 32'h0, 1, 1);
        // Random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 19) == 0), $urandom_range(0, 1),
                 $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) != 0));
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
